// File: rtl/core_rc_pkg.sv
// Shared types and constants for the core_rc recompute-scale producer.
// Supplies default RECOMPUTE_SCALE_WIDTH / RECOMPUTE_SHIFT_WIDTH when the build does not define them.
`ifndef RECOMPUTE_SCALE_WIDTH
`define RECOMPUTE_SCALE_WIDTH 16
`endif
`ifndef RECOMPUTE_SHIFT_WIDTH
`define RECOMPUTE_SHIFT_WIDTH 5
`endif

package core_rc_pkg;

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIN  = 2'd2,
    ST_PUSH = 2'd3
  } rc_state_e;

  localparam int SCALE_W = `RECOMPUTE_SCALE_WIDTH;
  localparam int SHIFT_W = `RECOMPUTE_SHIFT_WIDTH;
  localparam logic [SCALE_W-1:0] SCALE_SAT = {SCALE_W{1'b1}};

  // Numerator width: TARGET_MAX shifted left by the largest possible rc_shift.
  function automatic int num_w(input int out_w);
    return out_w + (2 ** SHIFT_W);
  endfunction

endpackage

// File: rtl/core_rc_div_seq.sv
// Restoring divider, one quotient bit per cycle, NUM_W cycles after start.
// done is high during the cycle whose closing edge retires the final quotient bit.
module core_rc_div_seq #(
  parameter int NUM_W = 56,
  parameter int DEN_W = 24,
  parameter int QUO_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] numer,
  input  logic [DEN_W-1:0] denom,
  output logic             busy,
  output logic             done,
  output logic [QUO_W-1:0] quot,
  output logic [DEN_W-1:0] rem,
  output logic             ovf
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [CNT_W-1:0] cnt;
  logic [NUM_W-1:0] num_q;
  logic [DEN_W-1:0] den_q;
  logic [DEN_W:0]   rem_sh;
  logic [DEN_W-1:0] rem_sub;
  logic             ge;

  always_comb begin
    rem_sh  = {rem, num_q[NUM_W-1]};
    ge      = rem_sh >= {1'b0, den_q};
    rem_sub = rem_sh[DEN_W-1:0] - den_q;
  end

  assign busy = (cnt != '0);
  assign done = (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      num_q <= '0;
      den_q <= '0;
      quot  <= '0;
      rem   <= '0;
      ovf   <= 1'b0;
    end else if (start) begin
      cnt   <= CNT_W'(NUM_W);
      num_q <= numer;
      den_q <= denom;
      quot  <= '0;
      rem   <= '0;
      ovf   <= 1'b0;
    end else if (busy) begin
      cnt   <= cnt - 1'b1;
      num_q <= {num_q[NUM_W-2:0], 1'b0};
      quot  <= {quot[QUO_W-2:0], ge};
      rem   <= ge ? rem_sub : rem_sh[DEN_W-1:0];
      // Quotient bit index is cnt-1; anything at or above QUO_W cannot be represented.
      if (ge && (cnt > CNT_W'(QUO_W)))
        ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/core_rc_scale_gen.sv
// Recompute-scale producer: frame max |in_data| -> (TARGET_MAX << rc_shift) / max_abs, credit-limited push.
// Build option RC_SCALE_GEN_ROUND_EN selects round-half-up; otherwise the quotient is truncated.
//   state | meaning
//   ACC   | accept samples, track max |in_data|
//   DIV   | sequential divide in progress
//   FIN   | round and saturate the quotient
//   PUSH  | push scale when a FIFO credit is free, else stall
module core_rc_scale_gen
  import core_rc_pkg::*;
#(
  parameter int IN_DATA_WIDTH        = 24,
  parameter int OUT_DATA_WIDTH       = 24,
  parameter int RECOMPUTE_FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [`RECOMPUTE_SHIFT_WIDTH-1:0] rc_shift,
  input  logic signed [IN_DATA_WIDTH-1:0]   in_data,
  input  logic                              in_data_vld,
  input  logic                              in_data_last,
  output logic                              in_ready,
  input  logic                              scale_release,
  output logic [`RECOMPUTE_SCALE_WIDTH-1:0] rc_scale,
  output logic                              rc_scale_vld,
  output logic                              rc_scale_clear,
  output logic                              scale_sat,
  output logic                              error
);

  localparam int NUM_W      = num_w(OUT_DATA_WIDTH);
  localparam int TARGET_MAX = (2 ** (OUT_DATA_WIDTH - 1)) - 1;
  localparam int CRD_W      = $clog2(RECOMPUTE_FIFO_DEPTH + 1);

  rc_state_e                state, state_nxt;
  logic [IN_DATA_WIDTH-1:0] max_abs, in_abs, beat_max, div_den;
  logic [NUM_W-1:0]         numer;
  logic [CRD_W-1:0]         credits;
  logic [SCALE_W-1:0]       div_quot, fin_scale, fin_val_c;
  logic [IN_DATA_WIDTH-1:0] div_rem;
  logic                     div_busy, div_done, div_ovf, div_start;
  logic                     fin_sat, fin_sat_c;
  logic                     beat, push, clr, unused_div;

  assign in_ready = (state == ST_ACC);
  assign beat     = in_data_vld && in_ready;
  assign in_abs   = in_data[IN_DATA_WIDTH-1] ? $unsigned(-in_data) : $unsigned(in_data);
  assign beat_max = (in_abs > max_abs) ? in_abs : max_abs;
  assign numer    = NUM_W'(TARGET_MAX) << rc_shift;
  assign push     = (state == ST_PUSH) && (credits < CRD_W'(RECOMPUTE_FIFO_DEPTH));
  assign clr      = scale_release && (credits != '0);

  core_rc_div_seq #(
    .NUM_W (NUM_W),
    .DEN_W (IN_DATA_WIDTH),
    .QUO_W (SCALE_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .numer (numer),
    .denom (beat_max),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot),
    .rem   (div_rem),
    .ovf   (div_ovf)
  );

`ifdef RC_SCALE_GEN_ROUND_EN
  logic               round_up;
  logic [SCALE_W:0]   rounded;
  assign round_up   = {div_rem, 1'b0} >= {1'b0, div_den};
  assign rounded    = {1'b0, div_quot} + (SCALE_W+1)'(round_up);
  assign fin_sat_c  = div_ovf || rounded[SCALE_W] || (div_den == '0);
  assign fin_val_c  = rounded[SCALE_W-1:0];
  assign unused_div = div_busy;
`else
  assign fin_sat_c  = div_ovf || (div_den == '0);
  assign fin_val_c  = div_quot;
  assign unused_div = div_busy ^ (^div_rem);
`endif

  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    case (state)
      ST_ACC: begin
        if (beat && in_data_last) begin
          div_start = 1'b1;
          state_nxt = ST_DIV;
        end
      end
      ST_DIV:  if (div_done) state_nxt = ST_FIN;
      ST_FIN:  state_nxt = ST_PUSH;
      ST_PUSH: if (push) state_nxt = ST_ACC;
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_ACC;
      max_abs        <= '0;
      div_den        <= '0;
      fin_scale      <= '0;
      fin_sat        <= 1'b0;
      rc_scale       <= '0;
      scale_sat      <= 1'b0;
      rc_scale_vld   <= 1'b0;
      rc_scale_clear <= 1'b0;
      credits        <= '0;
      error          <= 1'b0;
    end else begin
      state          <= state_nxt;
      rc_scale_vld   <= push;
      rc_scale_clear <= clr;
      if (beat)
        max_abs <= in_data_last ? '0 : beat_max;
      if (div_start)
        div_den <= beat_max;
      if (state == ST_FIN) begin
        fin_scale <= fin_sat_c ? SCALE_SAT : fin_val_c;
        fin_sat   <= fin_sat_c;
      end
      if (push) begin
        rc_scale  <= fin_scale;
        scale_sat <= fin_sat;
      end
      if (push && !clr)
        credits <= credits + 1'b1;
      else if (!push && clr)
        credits <= credits - 1'b1;
      if ((in_data_vld && !in_ready) || (scale_release && (credits == '0)))
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_rc_scale_gen.sv
// Directed self-checking bench for core_rc_scale_gen (24-bit data, 16-bit scale, 5-bit shift).
// Expected scales follow RC_SCALE_GEN_ROUND_EN when it is defined for the build.
module tb_core_rc_scale_gen;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [4:0]         rc_shift = '0;
  logic signed [23:0] in_data = '0;
  logic               in_data_vld = 1'b0;
  logic               in_data_last = 1'b0;
  logic               scale_release = 1'b0;
  logic               in_ready, rc_scale_vld, rc_scale_clear, scale_sat, error;
  logic [15:0]        rc_scale;

  int total = 0;
  int bad   = 0;

  localparam int LAT = 58;
`ifdef RC_SCALE_GEN_ROUND_EN
  localparam int EXP_1M = 8590, EXP_NEG = 1024, EXP_4096 = 2048;
`else
  localparam int EXP_1M = 8589, EXP_NEG = 1023, EXP_4096 = 2047;
`endif

  always #5 clk = ~clk;

  core_rc_scale_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rc_shift       (rc_shift),
    .in_data        (in_data),
    .in_data_vld    (in_data_vld),
    .in_data_last   (in_data_last),
    .in_ready       (in_ready),
    .scale_release  (scale_release),
    .rc_scale       (rc_scale),
    .rc_scale_vld   (rc_scale_vld),
    .rc_scale_clear (rc_scale_clear),
    .scale_sat      (scale_sat),
    .error          (error)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_data_vld = 1'b0;
    in_data_last = 1'b0;
    scale_release = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the negedge right after the edge that accepted the last beat.
  task automatic drive_frame(input int n, input logic signed [23:0] d0, input logic signed [23:0] d1,
                             input logic signed [23:0] d2, input logic [4:0] sh);
    logic signed [23:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_data = d[i];
      in_data_vld = 1'b1;
      in_data_last = (i == n - 1);
      rc_shift = sh;
    end
    @(negedge clk);
    in_data_vld = 1'b0;
    in_data_last = 1'b0;
  endtask

  task automatic wait_push(output int n);
    n = 0;
    while (rc_scale_vld !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic watch_idle(input int k, output int seen);
    seen = 0;
    repeat (k) begin
      @(negedge clk);
      if (rc_scale_vld === 1'b1) seen++;
    end
  endtask

  task automatic pulse_release();
    @(negedge clk);
    scale_release = 1'b1;
    @(negedge clk);
    scale_release = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (rc_scale_vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", rc_scale_vld); end
    total++; if (rc_scale_clear !== 1'b0) begin bad++; $display("FAIL reset_clear: got %b want 0", rc_scale_clear); end
    total++; if (rc_scale !== 16'd0) begin bad++; $display("FAIL reset_scale: got %0d want 0", rc_scale); end
    total++; if (scale_sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b want 0", scale_sat); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error); end
  endtask

  task automatic test_frame_basic();
    int n;
    drive_frame(3, 24'sd100, -24'sd1000000, 24'sd5, 5'd10);
    wait_push(n);
    total++; if (n !== LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", n, LAT); end
    total++; if (rc_scale !== 16'(EXP_1M)) begin bad++; $display("FAIL basic_scale: got %0d want %0d", rc_scale, EXP_1M); end
    total++; if (scale_sat !== 1'b0) begin bad++; $display("FAIL basic_sat: got %b want 0", scale_sat); end
    @(negedge clk);
    total++; if (rc_scale_vld !== 1'b0) begin bad++; $display("FAIL basic_vld_pulse: got %b want 0", rc_scale_vld); end
    pulse_release();
    total++; if (rc_scale_clear !== 1'b1) begin bad++; $display("FAIL basic_clear: got %b want 1", rc_scale_clear); end
    @(negedge clk);
    total++; if (rc_scale_clear !== 1'b0) begin bad++; $display("FAIL basic_clear_pulse: got %b want 0", rc_scale_clear); end
  endtask

  task automatic test_saturation();
    int n;
    drive_frame(1, 24'sd4096, 24'sd0, 24'sd0, 5'd10);
    wait_push(n);
    total++; if (rc_scale !== 16'hFFFF) begin bad++; $display("FAIL sat_ovf_scale: got %0h want ffff", rc_scale); end
    total++; if (scale_sat !== 1'b1) begin bad++; $display("FAIL sat_ovf_flag: got %b want 1", scale_sat); end
    pulse_release();
    drive_frame(2, 24'sd0, 24'sd0, 24'sd0, 5'd3);
    wait_push(n);
    total++; if (rc_scale !== 16'hFFFF) begin bad++; $display("FAIL sat_zero_scale: got %0h want ffff", rc_scale); end
    total++; if (scale_sat !== 1'b1) begin bad++; $display("FAIL sat_zero_flag: got %b want 1", scale_sat); end
    pulse_release();
  endtask

  task automatic test_rounding();
    int n;
    drive_frame(1, -24'sd8388608, 24'sd0, 24'sd0, 5'd10);
    wait_push(n);
    total++; if (rc_scale !== 16'(EXP_NEG)) begin bad++; $display("FAIL round_neg_scale: got %0d want %0d", rc_scale, EXP_NEG); end
    total++; if (scale_sat !== 1'b0) begin bad++; $display("FAIL round_neg_sat: got %b want 0", scale_sat); end
    pulse_release();
    drive_frame(1, 24'sd4096, 24'sd0, 24'sd0, 5'd0);
    wait_push(n);
    total++; if (rc_scale !== 16'(EXP_4096)) begin bad++; $display("FAIL round_4096_scale: got %0d want %0d", rc_scale, EXP_4096); end
    pulse_release();
  endtask

  task automatic test_back_to_back();
    int n, seen;
    for (int f = 0; f < 4; f++) begin
      drive_frame(1, 24'sd4096, 24'sd0, 24'sd0, 5'd0);
      wait_push(n);
      total++; if (n !== LAT) begin bad++; $display("FAIL b2b_push%0d_latency: got %0d want %0d", f, n, LAT); end
    end
    drive_frame(1, 24'sd4096, 24'sd0, 24'sd0, 5'd0);
    watch_idle(80, seen);
    total++; if (seen !== 0) begin bad++; $display("FAIL b2b_stall_vld: got %0d pushes want 0", seen); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready: got %b want 0", in_ready); end
    pulse_release();
    total++; if (rc_scale_clear !== 1'b1) begin bad++; $display("FAIL b2b_release_clear: got %b want 1", rc_scale_clear); end
    total++; if (rc_scale_vld !== 1'b0) begin bad++; $display("FAIL b2b_release_vld_early: got %b want 0", rc_scale_vld); end
    @(negedge clk);
    total++; if (rc_scale_vld !== 1'b1) begin bad++; $display("FAIL b2b_fifth_push: got %b want 1", rc_scale_vld); end
    total++; if (rc_scale !== 16'(EXP_4096)) begin bad++; $display("FAIL b2b_fifth_scale: got %0d want %0d", rc_scale, EXP_4096); end
    for (int r = 0; r < 4; r++) begin
      pulse_release();
      total++; if (rc_scale_clear !== 1'b1) begin bad++; $display("FAIL b2b_drain%0d_clear: got %b want 1", r, rc_scale_clear); end
    end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL b2b_error: got %b want 0", error); end
  endtask

  task automatic test_coincident();
    int n, seen;
    for (int f = 0; f < 3; f++) begin
      drive_frame(1, 24'sd4096, 24'sd0, 24'sd0, 5'd0);
      wait_push(n);
    end
    drive_frame(1, 24'sd4096, 24'sd0, 24'sd0, 5'd0);
    repeat (LAT - 1) @(negedge clk);
    scale_release = 1'b1;
    @(negedge clk);
    scale_release = 1'b0;
    total++; if (rc_scale_vld !== 1'b1) begin bad++; $display("FAIL coinc_push: got %b want 1", rc_scale_vld); end
    total++; if (rc_scale_clear !== 1'b1) begin bad++; $display("FAIL coinc_clear: got %b want 1", rc_scale_clear); end
    drive_frame(1, 24'sd4096, 24'sd0, 24'sd0, 5'd0);
    wait_push(n);
    total++; if (n !== LAT) begin bad++; $display("FAIL coinc_last_credit: got %0d want %0d", n, LAT); end
    drive_frame(1, 24'sd4096, 24'sd0, 24'sd0, 5'd0);
    watch_idle(80, seen);
    total++; if (seen !== 0) begin bad++; $display("FAIL coinc_full_stall: got %0d pushes want 0", seen); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL coinc_full_ready: got %b want 0", in_ready); end
  endtask

  task automatic test_errors();
    apply_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL err_reset_ready: got %b want 1", in_ready); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL err_reset_error: got %b want 0", error); end
    pulse_release();
    total++; if (rc_scale_clear !== 1'b0) begin bad++; $display("FAIL err_empty_clear: got %b want 0", rc_scale_clear); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL err_empty_release: got %b want 1", error); end
    apply_reset();
    drive_frame(1, 24'sd1000, 24'sd0, 24'sd0, 5'd0);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL err_pre_drop: got %b want 0", error); end
    @(negedge clk);
    in_data_vld = 1'b1;
    @(negedge clk);
    in_data_vld = 1'b0;
    total++; if (error !== 1'b1) begin bad++; $display("FAIL err_drop_in_div: got %b want 1", error); end
  endtask

  task automatic test_reset_mid_div();
    int n, seen;
    apply_reset();
    drive_frame(1, 24'sd1000000, 24'sd0, 24'sd0, 5'd10);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL middiv_ready: got %b want 1", in_ready); end
    total++; if (rc_scale_vld !== 1'b0) begin bad++; $display("FAIL middiv_vld: got %b want 0", rc_scale_vld); end
    total++; if (rc_scale !== 16'd0) begin bad++; $display("FAIL middiv_scale: got %0d want 0", rc_scale); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL middiv_error: got %b want 0", error); end
    @(negedge clk);
    rst_n = 1'b1;
    watch_idle(80, seen);
    total++; if (seen !== 0) begin bad++; $display("FAIL middiv_no_push: got %0d pushes want 0", seen); end
    drive_frame(1, 24'sd1000000, 24'sd0, 24'sd0, 5'd10);
    wait_push(n);
    total++; if (n !== LAT) begin bad++; $display("FAIL middiv_next_latency: got %0d want %0d", n, LAT); end
    total++; if (rc_scale !== 16'(EXP_1M)) begin bad++; $display("FAIL middiv_next_scale: got %0d want %0d", rc_scale, EXP_1M); end
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_coincident();
    test_errors();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
